branch_resolver: RTL and testbench

EX-stage counterpart of the ID-stage branch predictor: it resolves every conditional branch and JALR once forwarded operands are available. It returns the registered update record (old_pc, old_branch_pc, old_predict, old_branch, branch_result) that the predictor consumes. On a misprediction it redirects fetch and flushes the wrong-path instructions in IF/ID and ID/EX.

---
 rtl/branch_resolver_pkg.sv | 33 +++
 rtl/branch_resolver_if.sv | 48 ++++
 rtl/branch_cmp.sv | 31 +++
 rtl/branch_resolver.sv | 130 +++++++++++++
 tb/tb_branch_resolver.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolver_pkg.sv
// ============================================================================
// branch_resolver_pkg : shared funct3 codes, FSM state and predictor update record
// Rev 1.0
// ============================================================================
`default_nettype none

package branch_resolver_pkg;

   localparam int BR_DATA_W = 32;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SQUASH = 1'b1
   } br_state_t;

   typedef struct packed {
      logic [BR_DATA_W-1:0] pc;
      logic [BR_DATA_W-1:0] branch_pc;
      logic                 predict;
      logic                 branch;
      logic                 result;
   } bp_update_t;

endpackage

`default_nettype wire

// File: rtl/branch_resolver_if.sv
// ============================================================================
// branch_resolver_if : EX-stage operands in, predictor update / redirect out
// Rev 1.0
// ============================================================================
`default_nettype none

interface branch_resolver_if #(
   parameter int DATA_W = 32
) ();
   logic              stall;
   logic              valid_in;
   logic              is_branch;
   logic              is_jalr;
   logic [2:0]        funct3;
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              predict_taken;
   logic [DATA_W-1:0] predict_target;

   logic [DATA_W-1:0] old_pc;
   logic [DATA_W-1:0] old_branch_pc;
   logic              old_predict;
   logic              old_branch;
   logic              branch_result;
   logic              redirect;
   logic [DATA_W-1:0] redirect_pc;
   logic              flush;
   logic [31:0]       stat_branches;
   logic [31:0]       stat_mispredicts;

   modport master (
      output stall, valid_in, is_branch, is_jalr, funct3, pc, imm, op_a, op_b,
             predict_taken, predict_target,
      input  old_pc, old_branch_pc, old_predict, old_branch, branch_result,
             redirect, redirect_pc, flush, stat_branches, stat_mispredicts
   );

   modport slave (
      input  stall, valid_in, is_branch, is_jalr, funct3, pc, imm, op_a, op_b,
             predict_taken, predict_target,
      output old_pc, old_branch_pc, old_predict, old_branch, branch_result,
             redirect, redirect_pc, flush, stat_branches, stat_mispredicts
   );
endinterface

`default_nettype wire

// File: rtl/branch_cmp.sv
// ============================================================================
// branch_cmp : combinational B-type condition evaluation from funct3
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_cmp
   import branch_resolver_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              taken
);
   always_comb begin
      taken = 1'b0;
      case (funct3)
         BEQ:     taken = (op_a == op_b);
         BNE:     taken = (op_a != op_b);
         BLT:     taken = ($signed(op_a) <  $signed(op_b));
         BGE:     taken = ($signed(op_a) >= $signed(op_b));
         BLTU:    taken = (op_a <  op_b);
         BGEU:    taken = (op_a >= op_b);
         default: taken = 1'b0;
      endcase
   end
endmodule

`default_nettype wire

// File: rtl/branch_resolver.sv
// ============================================================================
// branch_resolver : EX-stage branch/JALR resolution, predictor update, redirect
// Optional statistics counters under BRANCH_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int FLUSH_CYC = 1
) (
   input  logic            clk,
   input  logic            rst,
   branch_resolver_if.slave bus
);
   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYC);

   br_state_t         state, state_nx;
   logic [1:0]        cnt, cnt_nx;
   bp_update_t        rec;
   logic [DATA_W-1:0] redirect_pc_q;

   logic              squash, res, cmp_taken, taken, mispredict;
   logic [DATA_W-1:0] jalr_sum, target, next_pc;

   branch_cmp #(.DATA_W(DATA_W)) u_cmp (
      .funct3 (bus.funct3),
      .op_a   (bus.op_a),
      .op_b   (bus.op_b),
      .taken  (cmp_taken)
   );

   assign squash     = (state == SQUASH);
   assign res        = bus.valid_in & ~squash & (bus.is_branch | bus.is_jalr);
   assign jalr_sum   = bus.op_a + bus.imm;
   assign target     = bus.is_jalr ? {jalr_sum[DATA_W-1:1], 1'b0} : (bus.pc + bus.imm);
   assign taken      = bus.is_jalr | cmp_taken;
   assign next_pc    = taken ? target : (bus.pc + DATA_W'(4));
   // Compare the full next PC so wrong direction and wrong target look alike.
   assign mispredict = res & (next_pc != bus.predict_target);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (!bus.stall) begin
         case (state)
            IDLE: begin
               if (mispredict) begin
                  state_nx = SQUASH;
                  cnt_nx   = FLUSH_LOAD;
               end
            end
            SQUASH: begin
               if (cnt <= 2'd1) begin
                  state_nx = IDLE;
                  cnt_nx   = 2'd0;
               end else begin
                  cnt_nx = cnt - 2'd1;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rec           <= '0;
         redirect_pc_q <= '0;
      end else if (!bus.stall) begin
         rec.branch <= res;
         if (res) begin
            rec.pc        <= bus.pc;
            rec.branch_pc <= target;
            rec.predict   <= bus.predict_taken;
            rec.result    <= taken;
         end
         if (mispredict) begin
            redirect_pc_q <= next_pc;
         end
      end
   end

   assign bus.old_pc        = rec.pc;
   assign bus.old_branch_pc = rec.branch_pc;
   assign bus.old_predict   = rec.predict;
   assign bus.old_branch    = rec.branch;
   assign bus.branch_result = rec.result;
   // Counter sits at its load value only during the first SQUASH cycle.
   assign bus.redirect      = squash & (cnt == FLUSH_LOAD);
   assign bus.redirect_pc   = redirect_pc_q;
   assign bus.flush         = squash;

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_br, stat_mp;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_br <= 32'd0;
         stat_mp <= 32'd0;
      end else if (!bus.stall) begin
         if (res)        stat_br <= stat_br + 32'd1;
         if (mispredict) stat_mp <= stat_mp + 32'd1;
      end
   end

   assign bus.stat_branches    = stat_br;
   assign bus.stat_mispredicts = stat_mp;
`else
   assign bus.stat_branches    = 32'd0;
   assign bus.stat_mispredicts = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
// ============================================================================
// tb_branch_resolver : directed and randomized checks against a reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolver;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_resolver_if #(.DATA_W(32)) bus ();

   branch_resolver #(.DATA_W(32), .FLUSH_CYC(FC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int          m_left  = 0;
   bit          m_first = 1'b0;
   bit          m_chk_rpc = 1'b0;
   logic [31:0] m_old_pc = '0, m_old_bpc = '0, m_rpc = '0;
   bit          m_pred = 1'b0, m_br = 1'b0, m_res = 1'b0;
   logic [31:0] m_sbr = '0, m_smp = '0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void ref_resolve(input logic [2:0] f3, input bit jalr,
                                       input logic [31:0] pc, input logic [31:0] imm,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output bit tk, output logic [31:0] tgt,
                                       output logic [31:0] nxt);
      if (jalr) begin
         tk  = 1'b1;
         tgt = (a + imm) & 32'hFFFF_FFFE;
         nxt = tgt;
      end else begin
         case (f3)
            3'd0:    tk = (a == b);
            3'd1:    tk = (a != b);
            3'd4:    tk = ($signed(a) <  $signed(b));
            3'd5:    tk = ($signed(a) >= $signed(b));
            3'd6:    tk = (a <  b);
            3'd7:    tk = (a >= b);
            default: tk = 1'b0;
         endcase
         tgt = pc + imm;
         nxt = tk ? tgt : pc + 32'd4;
      end
   endfunction

   task automatic model_step();
      bit tk, live, mp;
      logic [31:0] tgt, nxt;
      if (rst) begin
         m_left = 0; m_first = 0; m_chk_rpc = 1;
         m_old_pc = '0; m_old_bpc = '0; m_rpc = '0;
         m_pred = 0; m_br = 0; m_res = 0; m_sbr = '0; m_smp = '0;
         return;
      end
      m_chk_rpc = 0;
      if (bus.stall) return;
      live = bus.valid_in && (m_left == 0) && (bus.is_branch || bus.is_jalr);
      ref_resolve(bus.funct3, bus.is_jalr, bus.pc, bus.imm, bus.op_a, bus.op_b, tk, tgt, nxt);
      mp = live && (nxt !== bus.predict_target);
      m_br = live;
      if (live) begin
         m_old_pc = bus.pc; m_old_bpc = tgt; m_pred = bus.predict_taken; m_res = tk;
         m_sbr = m_sbr + 1;
      end
      if (m_left > 0) begin
         m_left--;
         m_first = 0;
      end else if (mp) begin
         m_left = FC; m_first = 1; m_rpc = nxt;
         m_smp = m_smp + 1;
      end
   endtask

   task automatic check_outputs();
      bit exp_redir;
      exp_redir = m_first && (m_left > 0);
      check_val("old_branch",    32'(bus.old_branch),    32'(m_br));
      check_val("old_pc",        bus.old_pc,             m_old_pc);
      check_val("old_branch_pc", bus.old_branch_pc,      m_old_bpc);
      check_val("old_predict",   32'(bus.old_predict),   32'(m_pred));
      check_val("branch_result", 32'(bus.branch_result), 32'(m_res));
      check_val("redirect",      32'(bus.redirect),      32'(exp_redir));
      check_val("flush",         32'(bus.flush),         32'(m_left > 0));
      if (exp_redir || m_chk_rpc) check_val("redirect_pc", bus.redirect_pc, m_rpc);
`ifdef BRANCH_STATS_EN
      check_val("stat_branches",    bus.stat_branches,    m_sbr);
      check_val("stat_mispredicts", bus.stat_mispredicts, m_smp);
`else
      check_val("stat_branches",    bus.stat_branches,    32'd0);
      check_val("stat_mispredicts", bus.stat_mispredicts, 32'd0);
`endif
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic drive(input bit v, input bit br, input bit jr, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit pt, input logic [31:0] ptgt);
      bus.valid_in = v; bus.is_branch = br; bus.is_jalr = jr; bus.funct3 = f3;
      bus.pc = pc; bus.imm = imm; bus.op_a = a; bus.op_b = b;
      bus.predict_taken = pt; bus.predict_target = ptgt;
   endtask

   task automatic idle();
      drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
   endtask

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 4))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] smp0;
      bus.stall = 1'b0;
      idle();
      rst = 1'b1;
      cycle();
      cycle();
      check_val("reset_redirect_pc", bus.redirect_pc, 32'h0);
      rst = 1'b0;
      cycle();

      // BEQ predicted correctly
      drive(1, 1, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1, 32'h120);
      cycle();
      check_val("beq_no_redirect", 32'(bus.redirect), 32'd0);
      check_val("beq_result",      32'(bus.branch_result), 32'd1);
      check_val("beq_target",      bus.old_branch_pc, 32'h120);

      // BLT signed mispredict, then a live branch during SQUASH is dropped
      drive(1, 1, 0, 3'd4, 32'h100, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 32'h104);
      cycle();
      check_val("blt_redirect",    32'(bus.redirect), 32'd1);
      check_val("blt_redirect_pc", bus.redirect_pc, 32'h140);
      check_val("blt_flush",       32'(bus.flush), 32'd1);
      drive(1, 1, 0, 3'd0, 32'h200, 32'h10, 32'd7, 32'd7, 0, 32'h204);
      cycle();
      check_val("squash_ignored",  32'(bus.old_branch), 32'd0);
      idle();
      cycle();
      check_val("flush_done",      32'(bus.flush), 32'd0);

      // JALR target clears bit 0
      drive(1, 0, 1, 3'd0, 32'h3000, 32'h0, 32'h2003, 32'h0, 1, 32'h2000);
      cycle();
      check_val("jalr_redirect",    32'(bus.redirect), 32'd1);
      check_val("jalr_redirect_pc", bus.redirect_pc, 32'h2002);
      idle();
      repeat (3) cycle();

      // Mispredict held off by stall, then stall inside SQUASH
      smp0 = bus.stat_mispredicts;
      drive(1, 1, 0, 3'd6, 32'h400, 32'h80, 32'd1, 32'd2, 0, 32'h404);
      bus.stall = 1'b1;
      repeat (3) cycle();
      check_val("stall_no_redirect", 32'(bus.redirect), 32'd0);
      bus.stall = 1'b0;
      cycle();
      check_val("stall_redirect",    32'(bus.redirect), 32'd1);
      idle();
      bus.stall = 1'b1;
      repeat (3) cycle();
      check_val("stall_hold_redir",  32'(bus.redirect), 32'd1);
      bus.stall = 1'b0;
      repeat (3) cycle();
`ifdef BRANCH_STATS_EN
      check_val("stall_mp_delta", bus.stat_mispredicts - smp0, 32'd1);
`else
      check_val("stall_mp_delta", bus.stat_mispredicts - smp0, 32'd0);
`endif

      // Reset in the middle of SQUASH
      drive(1, 1, 0, 3'd1, 32'h500, 32'h8, 32'd3, 32'd4, 0, 32'h504);
      cycle();
      idle();
      rst = 1'b1;
      cycle();
      check_val("rst_redirect", 32'(bus.redirect), 32'd0);
      check_val("rst_flush",    32'(bus.flush), 32'd0);
      rst = 1'b0;
      cycle();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit tk, jr, v;
         logic [2:0]  f3;
         logic [31:0] pc, imm, a, b, tgt, nxt, ptgt;
         rst       = ($urandom_range(0, 49) == 0);
         bus.stall = ($urandom_range(0, 4) == 0);
         v   = ($urandom_range(0, 3) != 0);
         jr  = ($urandom_range(0, 4) == 0);
         f3  = 3'($urandom);
         pc  = $urandom & 32'hFFFF_FFFC;
         imm = $urandom_range(0, 1) ? {20'hFFFFF, 12'($urandom)} : {20'h0, 12'($urandom)};
         a   = pick_op();
         b   = ($urandom_range(0, 2) == 0) ? a : pick_op();
         ref_resolve(f3, jr, pc, imm, a, b, tk, tgt, nxt);
         case ($urandom_range(0, 3))
            0, 1:    ptgt = nxt;
            2:       ptgt = pc + 32'd4;
            default: ptgt = $urandom;
         endcase
         drive(v, ~jr & ($urandom_range(0, 5) != 0), jr, f3, pc, imm, a, b,
               ($urandom_range(0, 1) == 1), ptgt);
         cycle();
      end
      rst = 1'b0;
      bus.stall = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
